instr_encoder: RTL

//  Builds 32-bit MIPS instruction words from field-level requests and streams them

---
 rtl/instr_pkg.sv | 31 +++
 rtl/instr_pack.sv | 30 +++
 rtl/instr_encoder.sv | 113 +++++++++++
 3 files changed

// File: rtl/instr_pkg.sv
// Shared MIPS encoding constants: opcodes, request kinds and encoder FSM states.
// The control_unit decoder and the bench use the same definitions.
package instr_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;

  typedef enum logic [2:0] {
    KIND_R    = 3'd0,
    KIND_LW   = 3'd1,
    KIND_SW   = 3'd2,
    KIND_BEQ  = 3'd3,
    KIND_ADDI = 3'd4
  } kind_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  function automatic logic [31:0] itype(input logic [5:0]  op,
                                        input logic [4:0]  rs,
                                        input logic [4:0]  rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field-to-word packer for the five supported instruction classes.
// Kinds outside R/LW/SW/BEQ/ADDI drop o_legal and produce a zero word.
module instr_pack
  import instr_pkg::*;
(
  input  logic [2:0]  i_kind,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_shamt,
  input  logic [5:0]  i_funct,
  input  logic [15:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_legal
);

  always_comb begin
    o_word  = '0;
    o_legal = 1'b1;
    case (i_kind)
      KIND_R:    o_word = {OP_R, i_rs, i_rt, i_rd, i_shamt, i_funct};
      KIND_LW:   o_word = itype(OP_LW,   i_rs, i_rt, i_imm);
      KIND_SW:   o_word = itype(OP_SW,   i_rs, i_rt, i_imm);
      KIND_BEQ:  o_word = itype(OP_BEQ,  i_rs, i_rt, i_imm);
      KIND_ADDI: o_word = itype(OP_ADDI, i_rs, i_rt, i_imm);
      default:   o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streams packed MIPS words with sequential addresses to the imem loader through
// a single output register; stops accepting once DEPTH legal words have gone in.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ADDR_W:0]   word_cnt,
  output logic              full,
  output logic              err_illegal
);

  localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] L_ONE   = (ADDR_W+1)'(1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                w_run;
  logic                w_acc;
  logic                w_legal;
  logic [31:0]         w_word;
  logic [ADDR_W:0]     r_cnt;
  logic [ADDR_W:0]     w_cnt_inc;
  logic                r_err;
  logic                r_vld_p1;
  logic [31:0]         r_word_p1;
  logic [ADDR_W-1:0]   r_addr_p1;

  instr_pack u_pack (
    .i_kind  (in_kind),
    .i_rs    (in_rs),
    .i_rt    (in_rt),
    .i_rd    (in_rd),
    .i_shamt (in_shamt),
    .i_funct (in_funct),
    .i_imm   (in_imm),
    .o_word  (w_word),
    .o_legal (w_legal)
  );

  assign w_cnt_inc = r_cnt + L_ONE;
  assign in_ready  = w_run & ~clear & (~r_vld_p1 | out_ready);
  assign w_acc     = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (w_acc && w_legal && (w_cnt_inc == L_DEPTH)) w_state_nxt = ST_FULL;
      ST_FULL: if (clear) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_run = (r_state == ST_RUN);
    full  = (r_state == ST_FULL);
  end

  // Address equals the legal-word count, so one counter serves both and never wraps.
  always_ff @(posedge clk) begin
    if (rst || clear)          r_cnt <= '0;
    else if (w_acc && w_legal) r_cnt <= w_cnt_inc;
  end

  always_ff @(posedge clk) begin
    if (rst || clear)           r_err <= 1'b0;
    else if (w_acc && !w_legal) r_err <= 1'b1;
  end

  // Stage p1: output register; clear leaves a pending word to drain with its address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_word_p1 <= '0;
      r_addr_p1 <= '0;
    end else if (w_acc && w_legal) begin
      r_vld_p1  <= 1'b1;
      r_word_p1 <= w_word;
      r_addr_p1 <= r_cnt[ADDR_W-1:0];
    end else if (out_ready) begin
      r_vld_p1  <= 1'b0;
    end
  end

  assign out_valid   = r_vld_p1;
  assign out_word    = r_word_p1;
  assign out_addr    = r_addr_p1;
  assign word_cnt    = r_cnt;
  assign err_illegal = r_err;

endmodule
